// File: rtl/or2_pkg.sv
// Shared constants and helpers for the or2 leaf cell.
package or2_pkg;

  localparam int OR2_DEF_WIDTH = 1;
  localparam int OR2_DEF_CNT_W = 16;

  // Widest counter the saturating-increment helper supports.
  localparam int OR2_MAX_CNT_W = 32;

  // Returns cnt+1, clamped at the all-ones value of a cnt_w-bit counter.
  // cnt is carried zero-extended to OR2_MAX_CNT_W bits so that one helper
  // serves every counter width from 1 to OR2_MAX_CNT_W.
  function automatic logic [OR2_MAX_CNT_W-1:0] or2_sat_inc(
    input logic [OR2_MAX_CNT_W-1:0] cnt,
    input int unsigned              cnt_w
  );
    logic [OR2_MAX_CNT_W-1:0] max_v;
    max_v = {OR2_MAX_CNT_W{1'b1}} >> (OR2_MAX_CNT_W - cnt_w);
    return (cnt >= max_v) ? max_v : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/or2_sat_counter.sv
// Synchronous saturating up-counter; counts cycles with inc=1 and sticks
// at all-ones instead of wrapping. CNT_W must be in 1..OR2_MAX_CNT_W.
module or2_sat_counter
  import or2_pkg::*;
#(
  parameter int CNT_W = OR2_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [OR2_MAX_CNT_W-1:0] cnt_ext;
  logic [OR2_MAX_CNT_W-1:0] cnt_nxt;

  // Widen the counter and compute its clamped successor.
  always_comb begin
    cnt_ext = '0;
    cnt_ext[CNT_W-1:0] = cnt;
    cnt_nxt = or2_sat_inc(cnt_ext, CNT_W);
  end

  // Counter register; reset has priority over an increment request.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (inc) cnt <= cnt_nxt[CNT_W-1:0];
  end

endmodule

// File: rtl/or2.sv
// Bitwise OR2 with combinational and registered results.
// Optional activity statistics (sticky OR-accumulator and saturating count
// of active cycles) are built only when OR2_STATS_EN is defined; otherwise
// sticky and hi_cnt are constant 0 and carry no flops.
module or2
  import or2_pkg::*;
#(
  parameter int WIDTH = OR2_DEF_WIDTH,
  parameter int CNT_W = OR2_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [WIDTH-1:0] sticky
);

  // Zero-latency OR; independent of clk and rst.
  assign y = a | b;

  // Clock-aligned copy of the OR result.
  always_ff @(posedge clk) begin
    if (rst) y_q <= '0;
    else     y_q <= y;
  end

`ifdef OR2_STATS_EN
  // Per-bit accumulation of every 1 seen on y since the last reset.
  always_ff @(posedge clk) begin
    if (rst) sticky <= '0;
    else     sticky <= sticky | y;
  end

  or2_sat_counter #(.CNT_W(CNT_W)) u_hi_cnt (
    .clk (clk),
    .rst (rst),
    .inc (|y),
    .cnt (hi_cnt)
  );
`else
  assign sticky = '0;
  assign hi_cnt = '0;
`endif

endmodule

// File: tb/tb_or2.sv
// Directed bench for or2: truth table, registered path, reset priority,
// statistics accumulation and counter saturation. Expected statistics are
// zero when OR2_STATS_EN is undefined.
module tb_or2;

`ifdef OR2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // WIDTH=1 instance: truth table, registered path, reset priority
  logic        a1 = 1'b0, b1 = 1'b0;
  logic        y1, yq1, st1;
  logic [15:0] hc1;
  or2 #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .y(y1), .a(a1), .b(b1),
    .y_q(yq1), .hi_cnt(hc1), .sticky(st1));

  // WIDTH=4 instance: statistics scenario
  logic [3:0]  a4 = '0, b4 = '0;
  logic [3:0]  y4, yq4, st4;
  logic [15:0] hc4;
  or2 #(.WIDTH(4), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .y(y4), .a(a4), .b(b4),
    .y_q(yq4), .hi_cnt(hc4), .sticky(st4));

  // CNT_W=2 instance: saturation scenario
  logic       as = 1'b0, bs = 1'b0;
  logic       ys, yqs, sts;
  logic [1:0] hcs;
  or2 #(.WIDTH(1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .y(ys), .a(as), .b(bs),
    .y_q(yqs), .hi_cnt(hcs), .sticky(sts));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_in [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic       tt_y  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  int         sat_exp [6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    // Truth table with the clock stopped and reset held
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1];
      b1 = tt_in[i][0];
      #1;
      chk($sformatf("truth_%0d", i), {31'd0, y1}, {31'd0, tt_y[i]});
    end
    a1 = 1'bx; b1 = 1'b1; #1;
    chk("x_or_1", {31'd0, y1}, 32'd1);
    a1 = 1'b0; b1 = 1'b0;

    // Start clock; settle reset
    clk_en = 1'b1;
    tick(); tick();
    chk("rst_yq1", {31'd0, yq1}, 32'd0);
    chk("rst_st1", {31'd0, st1}, 32'd0);
    chk("rst_hc1", {16'd0, hc1}, 32'd0);
    chk("rst_yq4", {28'd0, yq4}, 32'd0);
    chk("rst_hcs", {30'd0, hcs}, 32'd0);

    // Reset priority with active inputs
    a1 = 1'b1; b1 = 1'b1; a4 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rp_y_%0d", i),  {31'd0, y1},  32'd1);
      chk($sformatf("rp_yq_%0d", i), {31'd0, yq1}, 32'd0);
      chk($sformatf("rp_st_%0d", i), {31'd0, st1}, 32'd0);
      chk($sformatf("rp_hc_%0d", i), {16'd0, hc1}, 32'd0);
      chk($sformatf("rp_st4_%0d", i), {28'd0, st4}, 32'd0);
    end
    a1 = 1'b0; b1 = 1'b0; a4 = 4'h0;
    rst = 1'b0;
    tick();
    chk("idle_yq1", {31'd0, yq1}, 32'd0);
    chk("idle_hc1", {16'd0, hc1}, 32'd0);

    // Registered path
    a1 = 1'b1; #1;
    chk("reg_y_now", {31'd0, y1}, 32'd1);
    chk("reg_yq_pre", {31'd0, yq1}, 32'd0);
    tick();
    chk("reg_yq_post", {31'd0, yq1}, 32'd1);
    a1 = 1'b0;
    tick();
    chk("reg_yq_back", {31'd0, yq1}, 32'd0);
    chk("reg_st1", {31'd0, st1}, STATS ? 32'd1 : 32'd0);
    chk("reg_hc1", {16'd0, hc1}, STATS ? 32'd1 : 32'd0);

    // Statistics: a=0001 x2, b=1000 x3, then idle
    a4 = 4'b0001;
    tick(); tick();
    chk("st_yq_a", {28'd0, yq4}, 32'h1);
    chk("st_hc_a", {16'd0, hc4}, STATS ? 32'd2 : 32'd0);
    a4 = 4'b0000; b4 = 4'b1000; #1;
    chk("st_y_b", {28'd0, y4}, 32'h8);
    tick(); tick(); tick();
    chk("st_yq_b", {28'd0, yq4}, 32'h8);
    b4 = 4'b0000;
    tick();
    chk("st_sticky", {28'd0, st4}, STATS ? 32'h9 : 32'h0);
    chk("st_hc", {16'd0, hc4}, STATS ? 32'd5 : 32'd0);
    chk("st_yq_0", {28'd0, yq4}, 32'h0);
    tick(); tick();
    chk("st_hc_hold", {16'd0, hc4}, STATS ? 32'd5 : 32'd0);
    chk("st_sticky_hold", {28'd0, st4}, STATS ? 32'h9 : 32'h0);

    // Saturation on a 2-bit counter
    as = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), {30'd0, hcs}, STATS ? 32'(sat_exp[i]) : 32'd0);
    end

    // Reset mid-operation, then restart from 0
    rst = 1'b1;
    tick();
    chk("mid_rst_hc", {30'd0, hcs}, 32'd0);
    chk("mid_rst_st", {31'd0, sts}, 32'd0);
    chk("mid_rst_yq", {31'd0, yqs}, 32'd0);
    rst = 1'b0;
    tick();
    chk("restart_hc", {30'd0, hcs}, STATS ? 32'd1 : 32'd0);
    chk("restart_yq", {31'd0, yqs}, 32'd1);
    as = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
